// File: rtl/busca_instrucao_pkg.sv
// Shared processor definitions for the instruction-fetch stage: widths,
// fetch FSM state encoding and the default memory-timeout budget.
package busca_instrucao_pkg;

    localparam int ADDR_W          = 16;
    localparam int INSTR_W         = 32;
    localparam int CNT_W           = 5;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        BUSCA   = 2'b01,
        ENTREGA = 2'b10,
        ERRO    = 2'b11
    } estado_t;

endpackage : busca_instrucao_pkg

// File: rtl/busca_instrucao_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface busca_instrucao_if;
    import busca_instrucao_pkg::*;

    logic               mem_req;
    logic [ADDR_W-1:0]  mem_endereco;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_dado;

    modport master (
        output mem_req,
        output mem_endereco,
        input  mem_ack,
        input  mem_dado
    );

    modport slave (
        input  mem_req,
        input  mem_endereco,
        output mem_ack,
        output mem_dado
    );

endinterface : busca_instrucao_if

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: issues one memory read per controlePC request,
// latches the instruction, advances pc and defers jumps until the fetch lands.
module busca_instrucao
    import busca_instrucao_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               controlePC,
    input  logic               saltar,
    input  logic [ADDR_W-1:0]  endereco_salto,
    busca_instrucao_if.master  mem,
    output logic [INSTR_W-1:0] instrucao,
    output logic               instr_valida,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_link,
    output logic               ocupado,
    output logic               erro_timeout
);

    estado_t            state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_link_q, pc_link_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               pend_q, pend_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  pc_inc;

    assign pc_inc = pc_q + 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= OCIOSO;
            pc_q        <= '0;
            pc_link_q   <= 16'h0001;
            instr_q     <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_link_q   <= pc_link_d;
            instr_q     <= instr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    // NOTE: every next-state signal gets a hold default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_link_d   = pc_link_q;
        instr_d     = instr_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        cnt_d       = cnt_q;

        case (state_q)
            OCIOSO: begin
                // A same-cycle jump retargets pc, so the new fetch reads the jump target.
                if (saltar) pc_d = endereco_salto;
                if (controlePC) begin
                    state_d = BUSCA;
                    cnt_d   = '0;
                end
            end

            BUSCA: begin
                if (saltar) begin
                    pend_d      = 1'b1;
                    pend_addr_d = endereco_salto;
                end
                if (mem.mem_ack) begin
                    instr_d   = mem.mem_dado;
                    pc_link_d = pc_inc;
                    if (saltar)      pc_d = endereco_salto;
                    else if (pend_q) pc_d = pend_addr_q;
                    else             pc_d = pc_inc;
                    pend_d  = 1'b0;
                    state_d = ENTREGA;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ERRO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ENTREGA: begin
                if (saltar) begin
                    pc_d   = endereco_salto;
                    pend_d = 1'b0;
                end
                state_d = OCIOSO;
            end

            default: ; // ERRO holds until reset
        endcase
    end

    assign mem.mem_req      = (state_q == BUSCA);
    assign mem.mem_endereco = pc_q;
    assign instrucao        = instr_q;
    assign instr_valida     = (state_q == ENTREGA);
    assign pc               = pc_q;
    assign pc_link          = pc_link_q;
    assign ocupado          = (state_q != OCIOSO);
    assign erro_timeout     = (state_q == ERRO);

endmodule : busca_instrucao
